div_clk_monitor: RTL and testbench

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

---
 rtl/div_clk_monitor.sv | 169 ++++++++++++++++
 tb/tb_div_clk_monitor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures the period and high time of a divided clock that
// is sampled as data in the clk domain, and reports lock, bad periods,
// timeouts and a saturating error count. The state is exposed on state_dbg.
//
// Handshake: there is no valid/ready pair. period_valid is a one-cycle
// strobe that qualifies period/high_cnt, and err/stuck are one-cycle strobes.
// Nothing pushes back on this block.
`timescale 1ns/1ps

module div_clk_monitor #(
    parameter int DIV_N    = 5,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic             stuck,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_dbg
);

    localparam int GR_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PER_GOOD  = CNT_W'(DIV_N);
    localparam logic [CNT_W-1:0] PER_TMO   = CNT_W'(2 * DIV_N);
    localparam logic [CNT_W-1:0] HIGH_MIN  = CNT_W'(DIV_N / 2);
    localparam logic [CNT_W-1:0] HIGH_MAX  = CNT_W'((DIV_N + 1) / 2);
    localparam logic [GR_W-1:0]  GR_LOCK   = GR_W'(LOCK_CNT);
    localparam logic [GR_W-1:0]  GR_ONE    = GR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state_q;
    logic              div_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [GR_W-1:0]   good_run_q;
    logic [CNT_W-1:0]  period_q, high_cnt_q, err_count_q, err_count_inc;
    logic              period_valid_q, locked_q, err_q, stuck_q;

    logic              rise;
    logic              good_period;
    logic              timeout;

    assign rise = div_in & ~div_q;

    // A period is good when it has the nominal length and a near-50% duty.
    // A saturated cnt can never equal DIV_N, so very long periods are bad.
    assign good_period = (cnt_q == PER_GOOD) &&
                         (hcnt_q >= HIGH_MIN) && (hcnt_q <= HIGH_MAX);

    // An edge arriving in the timeout cycle wins over the timeout.
    assign timeout = (cnt_q == PER_TMO) && !rise;

    assign err_count_inc = (err_count_q == CNT_MAX) ? err_count_q
                                                    : err_count_q + CNT_ONE;

    // Next values of the period and high-time counters; the rise cycle is the first of the new period.
    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        if (rise) begin
            cnt_d  = CNT_ONE;
            hcnt_d = CNT_ONE;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (div_in && (hcnt_q != CNT_MAX)) begin
                hcnt_d = hcnt_q + CNT_ONE;
            end
        end
    end

    // Sample register for edge detection and the free-running counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hcnt_q <= '0;
        end else begin
            div_q  <= div_in;
            cnt_q  <= cnt_d;
            hcnt_q <= hcnt_d;
        end
    end

    // Lock FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            good_run_q     <= '0;
            period_q       <= '0;
            high_cnt_q     <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
            stuck_q        <= 1'b0;
            err_count_q    <= '0;
        end else begin
            period_valid_q <= 1'b0;
            err_q          <= 1'b0;
            stuck_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The first edge only provides a reference; nothing to report yet.
                    if (rise) begin
                        state_q <= MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        period_q       <= cnt_q;
                        high_cnt_q     <= hcnt_q;
                        period_valid_q <= 1'b1;
                        if (good_period) begin
                            if (state_q == MEASURE) begin
                                good_run_q <= good_run_q + GR_ONE;
                                if ((good_run_q + GR_ONE) == GR_LOCK) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end
                        end else begin
                            err_q       <= 1'b1;
                            err_count_q <= err_count_inc;
                            good_run_q  <= '0;
                            locked_q    <= 1'b0;
                            state_q     <= MEASURE;
                        end
                    end else if (timeout) begin
                        stuck_q     <= 1'b1;
                        err_q       <= 1'b1;
                        err_count_q <= err_count_inc;
                        good_run_q  <= '0;
                        locked_q    <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    good_run_q <= '0;
                    locked_q   <= 1'b0;
                end
            endcase
        end
    end

    assign period       = period_q;
    assign high_cnt     = high_cnt_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign stuck        = stuck_q;
    assign err_count    = err_count_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: vector tables, hand-written corner sequences and
// random streams checked against a queue-based reference model.
`timescale 1ns/1ps

module tb_div_clk_monitor;

    localparam int N    = 5;
    localparam int N4   = 4;
    localparam int LOCK = 4;
    localparam int MAXC = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DIV_N = 5 instance
    logic       rst, div_in;
    logic [7:0] period, high_cnt, err_count;
    logic       period_valid, locked, err, stuck;
    logic [1:0] state_dbg;

    // DIV_N = 4 instance
    logic       rst4, div4;
    logic [7:0] period4, high_cnt4, err_count4;
    logic       period_valid4, locked4, err4, stuck4;
    logic [1:0] state_dbg4;

    div_clk_monitor #(.DIV_N(N), .CNT_W(8), .LOCK_CNT(LOCK)) dut (
        .clk(clk), .rst(rst), .div_in(div_in),
        .period(period), .high_cnt(high_cnt), .period_valid(period_valid),
        .locked(locked), .err(err), .stuck(stuck), .err_count(err_count),
        .state_dbg(state_dbg)
    );

    div_clk_monitor #(.DIV_N(N4), .CNT_W(8), .LOCK_CNT(LOCK)) dut4 (
        .clk(clk), .rst(rst4), .div_in(div4),
        .period(period4), .high_cnt(high_cnt4), .period_valid(period_valid4),
        .locked(locked4), .err(err4), .stuck(stuck4), .err_count(err_count4),
        .state_dbg(state_dbg4)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps the samples seen since the last rising edge; period is the number
    // of samples, high time is how many of them were 1.
    int mq[$];
    int m_prev, m_mode, m_good;          // mode: 0 idle, 1 measuring, 2 locked
    int e_period, e_high, e_pv, e_locked, e_err, e_stuck, e_errcnt;

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    task automatic model_step(input logic r, input logic v);
        int  hsum;
        bit  is_rise, is_good;
        e_pv = 0; e_err = 0; e_stuck = 0;
        if (!r) begin
            m_mode = 0; m_good = 0; m_prev = 0;
            e_period = 0; e_high = 0; e_locked = 0; e_errcnt = 0;
            mq.delete();
        end else begin
            is_rise = (v == 1'b1) && (m_prev == 0);
            if (is_rise) begin
                if (m_mode != 0) begin
                    hsum = 0;
                    foreach (mq[k]) hsum += mq[k];
                    e_period = sat(mq.size());
                    e_high   = sat(hsum);
                    e_pv     = 1;
                    is_good  = (mq.size() == N) && (hsum >= N / 2) && (hsum <= (N + 1) / 2);
                    if (is_good) begin
                        if (m_mode == 1) begin
                            m_good++;
                            if (m_good >= LOCK) begin
                                m_mode = 2;
                                e_locked = 1;
                            end
                        end
                    end else begin
                        e_err = 1;
                        e_errcnt = sat(e_errcnt + 1);
                        m_good = 0;
                        e_locked = 0;
                        m_mode = 1;
                    end
                end else begin
                    m_mode = 1;
                end
                mq.delete();
                mq.push_back(1);
            end else begin
                if (m_mode != 0 && mq.size() == 2 * N) begin
                    e_stuck = 1;
                    e_err = 1;
                    e_errcnt = sat(e_errcnt + 1);
                    e_locked = 0;
                    m_good = 0;
                    m_mode = 0;
                end
                mq.push_back(int'(v));
                if (mq.size() > 300) void'(mq.pop_front());
            end
            m_prev = int'(v);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic r, input logic v);
        rst = r;
        div_in = v;
        model_step(r, v);
        @(posedge clk);
        #1;
        cyc++;
        chk("period", period, e_period);
        chk("high_cnt", high_cnt, e_high);
        chk("period_valid", period_valid, e_pv);
        chk("locked", locked, e_locked);
        chk("err", err, e_err);
        chk("stuck", stuck, e_stuck);
        chk("err_count", err_count, e_errcnt);
        chk("state", state_dbg, m_mode);
    endtask

    task automatic s(input logic v);
        step(1'b1, v);
    endtask

    // Remaining four cycles of an ideal 2-high/3-low period after its rise.
    task automatic tail4();
        s(1); s(0); s(0); s(0);
    endtask

    // Called right after a reference rise: four good periods must relock.
    task automatic relock(input string tag);
        tail4();
        repeat (3) begin
            s(1);
            tail4();
        end
        chk({tag, "_not_yet_locked"}, locked, 0);
        s(1);
        chk({tag, "_locked"}, locked, 1);
        chk({tag, "_pv"}, period_valid, 1);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic       pv;
        logic       lk;
        logic       er;
        logic [7:0] per;
        logic [7:0] hi;
    } vec_t;

    vec_t tab5[27];
    vec_t tab4[22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, len, hi;

        rst = 1'b0; div_in = 1'b0; rst4 = 1'b0; div4 = 1'b0;

        // Ideal divide-by-5 from reset: rises every 5 cycles, reports from the 2nd rise.
        for (int i = 0; i < 27; i++) begin
            int j;
            j = i - 2;
            if (i < 2) tab5[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
            else tab5[i] = '{1'b1, ((j % 5) < 2), (j >= 5 && (j % 5) == 0), (j >= 20),
                             1'b0, ((j >= 5) ? 8'd5 : 8'd0), ((j >= 5) ? 8'd2 : 8'd0)};
        end
        // DIV_N = 4 instance with a 2/2 stream.
        for (int i = 0; i < 22; i++) begin
            int j;
            j = i - 2;
            if (i < 2) tab4[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
            else tab4[i] = '{1'b1, ((j % 4) < 2), (j >= 4 && (j % 4) == 0), (j >= 16),
                             1'b0, ((j >= 4) ? 8'd4 : 8'd0), ((j >= 4) ? 8'd2 : 8'd0)};
        end

        // DIV_N = 4 table; the DIV_N = 5 instance is held in reset meanwhile.
        for (int i = 0; i < 22; i++) begin
            rst4 = tab4[i].r;
            div4 = tab4[i].v;
            @(posedge clk);
            #1;
            cyc++;
            chk("n4_pv", period_valid4, tab4[i].pv);
            chk("n4_locked", locked4, tab4[i].lk);
            chk("n4_err", err4, tab4[i].er);
            chk("n4_period", period4, tab4[i].per);
            chk("n4_high", high_cnt4, tab4[i].hi);
        end
        rst4 = 1'b0;

        // DIV_N = 5 table (also checked against the model inside step).
        for (int i = 0; i < 27; i++) begin
            step(tab5[i].r, tab5[i].v);
            chk("tab_pv", period_valid, tab5[i].pv);
            chk("tab_locked", locked, tab5[i].lk);
            chk("tab_err", err, tab5[i].er);
            chk("tab_period", period, tab5[i].per);
            chk("tab_high", high_cnt, tab5[i].hi);
        end

        // One 6-cycle period while locked, then relock.
        s(1);
        s(1); s(0); s(0); s(0); s(0);
        s(1);
        chk("p6_period", period, 6);
        chk("p6_err", err, 1);
        chk("p6_locked", locked, 0);
        chk("p6_err_count", err_count, 1);
        relock("p6");

        // Hold low while locked: timeout exactly 10 cycles after the last rise.
        tail4();
        repeat (5) s(0);
        chk("tmo_early_stuck", stuck, 0);
        s(0);
        chk("tmo_stuck", stuck, 1);
        chk("tmo_err", err, 1);
        chk("tmo_locked", locked, 0);
        chk("tmo_state_idle", state_dbg, 0);
        chk("tmo_err_count", err_count, 2);
        repeat (4) s(0);
        chk("idle_no_timeout", stuck, 0);
        s(1);
        chk("idle_rise_no_pv", period_valid, 0);
        relock("tmo");

        // Duty fault: period 5 with 4 high cycles.
        s(1); s(1); s(1); s(0);
        s(1);
        chk("duty_err", err, 1);
        chk("duty_period", period, 5);
        chk("duty_high", high_cnt, 4);
        chk("duty_locked", locked, 0);
        chk("duty_err_count", err_count, 3);
        relock("duty");

        // One-cycle reset while locked, with div_in high across the release.
        step(1'b0, 1'b1);
        chk("rst_locked", locked, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_period", period, 0);
        chk("rst_state", state_dbg, 0);
        s(1);
        chk("rst_first_rise_state", state_dbg, 1);
        chk("rst_first_rise_no_pv", period_valid, 0);
        tail4();
        s(1);
        chk("rst_first_period", period, 5);

        // Rise exactly in the timeout cycle: bad 10-cycle period, no stuck.
        s(1);
        repeat (8) s(0);
        s(1);
        chk("edge_at_tmo_stuck", stuck, 0);
        chk("edge_at_tmo_err", err, 1);
        chk("edge_at_tmo_period", period, 10);

        // Random streams against the model.
        while (cyc < 1500) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                s(1); tail4();
            end else if (kind == 6) begin
                len = $urandom_range(1, 12);
                hi  = $urandom_range(1, len);
                for (int k = 0; k < len; k++) s(k < hi);
            end else if (kind == 7) begin
                repeat ($urandom_range(5, 15)) s(0);
            end else if (kind == 8) begin
                hi = $urandom_range(1, 4);
                for (int k = 0; k < 5; k++) s(k < hi);
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) step(1'b0, 1'($urandom_range(0, 1)));
                end else begin
                    s(1); tail4();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
